// File: rtl/kb_pkg.sv
// kb_pkg: shared constants and types for the keyboard event decoder
package kb_pkg;
    localparam int KB_COLS = 10;
    localparam int KB_ROWS = 7;
    typedef struct packed {
        logic [3:0] col;
        logic [2:0] row;
        logic       press;
    } kb_event_t;
    typedef enum logic {KB_IDLE, KB_EMIT} kb_state_e;
endpackage

// File: rtl/kb_event_fifo.sv
// kb_event_fifo: show-ahead event FIFO that drops pushes when full and flags it
module kb_event_fifo
    import kb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      push,
    input  kb_event_t din,
    input  logic      pop,
    output kb_event_t dout,
    output logic      valid,
    output logic      overflow
);
    localparam int AW = $clog2(DEPTH);
    kb_event_t     mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          full, do_pop, do_push;
    assign valid   = count != '0;
    assign full    = count == (AW+1)'(DEPTH);
    assign do_pop  = pop && valid;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];
    // storage, pointers, occupancy and the sticky drop flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
            if (push && !do_push) overflow <= 1'b1;
        end
    end
endmodule

// File: rtl/kb_event_decoder.sv
// kb_event_decoder: debounces scanned key columns and emits make/break events
module kb_event_decoder
    import kb_pkg::*;
#(
    parameter int DEBOUNCE   = 3,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       Clk,
    input  logic       Rst_n,
    input  logic       ColEn,
    input  logic [3:0] Col,
    input  logic [6:0] Row,
    output logic       KeyValid,
    input  logic       KeyReady,
    output logic [6:0] KeyCode,
    output logic       KeyPress,
    output logic       Overflow
);
    localparam logic [3:0] DB = 4'(DEBOUNCE);
    logic [KB_ROWS-1:0] last_q   [KB_COLS];
    logic [3:0]         cnt_q    [KB_COLS];
    logic [KB_ROWS-1:0] stable_q [KB_COLS];
    kb_state_e          state;
    logic [KB_ROWS-1:0] pend, pend_row, pend_rest;
    logic [3:0]         pend_col, sel, next_cnt;
    logic [2:0]         low_idx;
    logic               col_ok, commit;
    kb_event_t          ev, head;
    assign col_ok    = ColEn && Col < 4'(KB_COLS);
    assign sel       = col_ok ? Col : 4'd0;
    assign next_cnt  = Row != last_q[sel] ? 4'd1 : cnt_q[sel] >= DB ? DB : cnt_q[sel] + 4'd1;
    assign commit    = col_ok && next_cnt == DB && Row != stable_q[sel] && state == KB_IDLE;
    assign pend_rest = pend & (pend - 1'b1);
    assign ev        = '{col: pend_col, row: low_idx, press: pend_row[low_idx]};
    assign KeyCode   = {head.col, head.row};
    assign KeyPress  = head.press;
    // lowest set bit of the pending change mask
    always_comb begin
        low_idx = '0;
        for (int i = KB_ROWS - 1; i >= 0; i--) if (pend[i]) low_idx = 3'(i);
    end
    // per-column raw sample and agreement counter; runs even while emitting
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            for (int i = 0; i < KB_COLS; i++) begin
                last_q[i] <= '0;
                cnt_q[i]  <= '0;
            end
        end else if (col_ok) begin
            last_q[sel] <= Row;
            cnt_q[sel]  <= next_cnt;
        end
    end
    // commit a settled column, then emit one event per changed row
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            for (int i = 0; i < KB_COLS; i++) stable_q[i] <= '0;
            state    <= KB_IDLE;
            pend     <= '0;
            pend_row <= '0;
            pend_col <= '0;
        end else if (state == KB_IDLE) begin
            if (commit) begin
                pend          <= Row ^ stable_q[sel];
                pend_row      <= Row;
                pend_col      <= Col;
                stable_q[sel] <= Row;
                state         <= KB_EMIT;
            end
        end else begin
            pend <= pend_rest;
            if (pend_rest == '0) state <= KB_IDLE;
        end
    end
    kb_event_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (Clk),
        .rst_n   (Rst_n),
        .push    (state == KB_EMIT),
        .din     (ev),
        .pop     (KeyReady),
        .dout    (head),
        .valid   (KeyValid),
        .overflow(Overflow)
    );
endmodule

// File: doc/kb_event_decoder.md
# kb_event_decoder

Consumes the per-column row samples produced by the keyboard scan and turns them into debounced key make/break events. The scan drives one column per anode step, 0..9, and presents 7 row lines. This block sits directly downstream of the keyboard scanner. It tracks a stable 70-key state, emits one event per changed key through a small FIFO, and hands events to the sequencer or CPU side with a valid/ready handshake.

## Interface
Parameters:
- DEBOUNCE, default 3: consecutive identical samples of a column required before that column's stable state is updated. Range 1..15.
- FIFO_DEPTH, default 4: event FIFO depth. Power of two, at least 2.

Ports:
- Clk  in  1  system clock (Clock_1us domain).
- Rst_n  in  1  asynchronous, active-low reset.
- ColEn  in  1  one-cycle strobe: Col/Row valid this cycle.
- Col  in  4  BCD column index 0..9. Values >9 are ignored.
- Row  in  7  row sample, 1 = key pressed.
- KeyValid  out  1  FIFO head holds an event.
- KeyReady  in  1  consumer accepts the head event when KeyValid & KeyReady.
- KeyCode  out  7  {Col[3:0], rowIdx[2:0]}.
- KeyPress  out  1  1 = make, 0 = break.
- Overflow  out  1  sticky: an event was dropped because the FIFO was full.

## Operation
- Per-column state for 10 columns:
  - last[6:0]: previous raw sample.
  - cnt[3:0]: agreement counter.
  - stable[6:0]: debounced state.
- On each ColEn with Col ≤ 9:
  - If Row == last[Col], cnt[Col] is incremented, saturating at DEBOUNCE.
  - Otherwise last[Col] <= Row and cnt[Col] <= 1.
- Commit condition: the updated cnt reaches DEBOUNCE, Row != stable[Col], and the FSM is IDLE.
  - On commit, pend <= Row ^ stable[Col], pendRow <= Row, pendCol <= Col, stable[Col] <= Row, and the FSM goes to EMIT.
  - If the commit condition holds but the FSM is busy, nothing is committed. cnt stays saturated and the commit retries on that column's next ColEn.
- FSM states:
  - IDLE: waits for a commit.
  - EMIT: each cycle, takes the lowest set bit i of pend and pushes {pendCol, i, pendRow[i]} into the FIFO, then clears pend[i]. When the last bit is cleared, the FSM returns to IDLE.
- Events from one commit are emitted in ascending row index, makes and breaks interleaved by index.
- FIFO push when full (without a simultaneous pop): the event is dropped, Overflow <= 1, and the FSM still advances.
- FIFO push and pop in the same cycle are both honoured, including when the FIFO is full.
- Show-ahead FIFO: KeyCode/KeyPress show the head entry whenever KeyValid = 1. Their value is don't-care when KeyValid = 0.
- ColEn with Col > 9 changes no state.
- Reset, including mid-EMIT:
  - stable = 0 (all keys released), last = 0, cnt = 0, pend = 0, FSM = IDLE, FIFO empty.
  - All outputs 0: KeyValid = 0, KeyCode = 0, KeyPress = 0, Overflow = 0.
  - Overflow clears only on reset.

## Timing
- ColEn sampled at edge t. The commit registers at t. The first push happens at edge t+1 and KeyValid rises after edge t+1.
- A commit with k changed bits occupies EMIT for k cycles, pushing at edges t+1..t+k, and returns to IDLE after edge t+k.
- Pop occurs at the edge where KeyValid & KeyReady = 1. The next head is visible the following cycle. Throughput is 1 event per cycle.
- Minimum press-to-event latency is DEBOUNCE column visits plus 2 cycles.
- ColEn may arrive on back-to-back cycles for different columns. Debounce always runs; only commits are gated by FSM busy.

## Structure
- Shared package kb_pkg:
  - KB_COLS = 10, KB_ROWS = 7.
  - typedef kb_event_t {logic [3:0] col; logic [2:0] row; logic press;}.
  - typedef kb_state_e {KB_IDLE, KB_EMIT}.
- One sub-module: kb_event_fifo, a parameterised show-ahead FIFO of kb_event_t with full/empty and overflow-drop behaviour.
- Lowest-set-bit priority encoder is inline combinational logic.

## Test plan
- Reset, then ColEn on Col 3 with Row = 7'b0000100 for 3 visits. Response: exactly one event KeyCode = 7'h1A ({3,2}), KeyPress = 1, on the cycle after the 3rd ColEn+1.
- Bounce: Col 5 Row alternating 0x01/0x00 across 6 visits, then 0x01 held for 3 visits. Response: no event during the bounce, then one make with KeyCode = 7'h28.
- Multi-key: Col 0 stable 0x05, then 0x0A for 3 visits with KeyReady = 1. Response: 4 events in order 0/break, 1/make, 2/break, 3/make (codes 0x00..0x03) on consecutive cycles.
- Overflow, DEPTH = 4: KeyReady = 0, Col 9 transitions 0x00 → 0x3F. Response: 4 events queued (0x48..0x4B), Overflow = 1, and the first pop returns 0x48.
- Busy retry: a Col 1 commit lands while EMIT is active for Col 0. Response: the Col 1 event appears after its next ColEn, and no Col 1 state is lost.
- Asynchronous reset asserted mid-EMIT. Response: KeyValid = 0 and Overflow = 0 immediately, and a re-pressed key needs the full DEBOUNCE count again.
